// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and parity mode constants,
// common to the receiver and the matching transmitter.
package uart_pkg;
  localparam int PARITY_NONE = 0;
  localparam int PARITY_EVEN = 1;
  localparam int PARITY_ODD  = 2;

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK
  } uart_state_e;
endpackage

// File: rtl/uart_rx_cfg_if.sv
// Serial-in / frame-out bundle of the configurable UART receiver.
interface uart_rx_cfg_if #(parameter int DATA_BITS = 8);
  logic                 rx;
  logic [DATA_BITS-1:0] data;
  logic                 valid;
  logic                 parity_err;
  logic                 frame_err;
  logic                 busy;

  modport master (output rx, input data, valid, parity_err, frame_err, busy);
  modport slave  (input rx, output data, valid, parity_err, frame_err, busy);
endinterface

// File: rtl/uart_bit_timer.sv
// Bit-period tick counter; strobe marks mid-bit, counted from the last restart.
module uart_bit_timer #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic strobe
);
  localparam int CW = $clog2(CLKS_PER_BIT);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge rst)
    if (rst)                                          cnt <= '0;
    else if (restart || cnt == CW'(CLKS_PER_BIT - 1)) cnt <= '0;
    else                                              cnt <= cnt + 1'b1;

  // cnt is 0 in the first START cycle, so strobes land at +CPB/2, +3CPB/2, ...
  assign strobe = (cnt == CW'(CLKS_PER_BIT / 2));
endmodule

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: start/data/parity/stop sampling at mid-bit,
// one-cycle valid with sticky error flags, line-break wait after a low stop.
module uart_rx_cfg import uart_pkg::*; #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_BITS    = 8,
  parameter int PARITY_MODE  = PARITY_NONE,
  parameter int STOP_BITS    = 1
) (
  input logic          clk,
  input logic          rst,
  uart_rx_cfg_if.slave bus
);
  if (CLKS_PER_BIT < 4 || (CLKS_PER_BIT % 2) != 0) begin : g_bad_cpb
    $fatal(1, "uart_rx_cfg: CLKS_PER_BIT must be even and >= 4");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_db
    $fatal(1, "uart_rx_cfg: DATA_BITS must be 5..9");
  end
  if (PARITY_MODE < PARITY_NONE || PARITY_MODE > PARITY_ODD) begin : g_bad_par
    $fatal(1, "uart_rx_cfg: PARITY_MODE must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
    $fatal(1, "uart_rx_cfg: STOP_BITS must be 1 or 2");
  end

  logic                 rx_meta, rx_s, armed;
  logic [1:0]           sync_fill;
  uart_state_e          state, state_nx;
  logic                 restart, strobe, done;
  logic [3:0]           bit_cnt;
  logic [DATA_BITS-1:0] shreg, data_q;
  logic                 par_acc, perr_r, ferr_r;
  logic                 valid_q, perr_q, ferr_q;

  // armed stays low until the synchronizer holds a real high sample, so a line
  // that is already low when reset releases is not taken as a start edge.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      rx_meta   <= 1'b1;
      rx_s      <= 1'b1;
      sync_fill <= '0;
      armed     <= 1'b0;
    end else begin
      rx_meta   <= bus.rx;
      rx_s      <= rx_meta;
      sync_fill <= {sync_fill[0], 1'b1};
      if (sync_fill[1] && rx_s) armed <= 1'b1;
    end

  uart_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_timer (
    .clk     (clk),
    .rst     (rst),
    .restart (restart),
    .strobe  (strobe)
  );

  always_ff @(posedge clk or posedge rst)
    if (rst) state <= S_IDLE;
    else     state <= state_nx;

  always_comb begin
    state_nx = state;
    restart  = 1'b0;
    done     = 1'b0;
    unique case (state)
      S_IDLE:   if (armed && !rx_s) begin
                  state_nx = S_START;
                  restart  = 1'b1;
                end
      S_START:  if (strobe) state_nx = rx_s ? S_IDLE : S_DATA;
      S_DATA:   if (strobe && bit_cnt == 4'(DATA_BITS - 1))
                  state_nx = (PARITY_MODE != PARITY_NONE) ? S_PARITY : S_STOP;
      S_PARITY: if (strobe) state_nx = S_STOP;
      S_STOP:   if (strobe && bit_cnt == 4'(STOP_BITS - 1)) begin
                  done     = 1'b1;
                  state_nx = rx_s ? S_IDLE : S_BREAK;
                end
      S_BREAK:  if (rx_s) state_nx = S_IDLE;
      default:  state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      bit_cnt <= '0;
      shreg   <= '0;
      par_acc <= 1'b0;
      perr_r  <= 1'b0;
      ferr_r  <= 1'b0;
      data_q  <= '0;
      valid_q <= 1'b0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      valid_q <= done;
      if (state != state_nx)                                     bit_cnt <= '0;
      else if (strobe && (state == S_DATA || state == S_STOP))  bit_cnt <= bit_cnt + 1'b1;
      if (state == S_START) begin
        par_acc <= 1'b0;
        perr_r  <= 1'b0;
        ferr_r  <= 1'b0;
      end
      if (strobe) begin
        case (state)
          S_DATA: begin
            shreg   <= {rx_s, shreg[DATA_BITS-1:1]};
            par_acc <= par_acc ^ rx_s;
          end
          S_PARITY: perr_r <= (par_acc ^ rx_s) != (PARITY_MODE == PARITY_ODD);
          S_STOP:   if (!rx_s) ferr_r <= 1'b1;
          default: ;
        endcase
      end
      // The final stop sample is folded in directly; ferr_r only covers earlier ones.
      if (done) begin
        data_q <= shreg;
        perr_q <= perr_r;
        ferr_q <= ferr_r | ~rx_s;
      end
    end

  assign bus.data       = data_q;
  assign bus.valid      = valid_q;
  assign bus.parity_err = perr_q;
  assign bus.frame_err  = ferr_q;
  assign bus.busy       = (state != S_IDLE);
endmodule

// File: tb/tb_uart_rx_cfg.sv
// Bench for uart_rx_cfg: three receiver configurations, directed corners,
// a vector table and random frames scored against a frame-level model.
module tb_uart_rx_cfg;
  import uart_pkg::*;

  localparam int CPB0 = 16, CPB1 = 8, CPB2 = 6;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic rx0 = 1'b1, rx1 = 1'b1, rx2 = 1'b1;

  uart_rx_cfg_if #(.DATA_BITS(8)) if0 ();
  uart_rx_cfg_if #(.DATA_BITS(8)) if1 ();
  uart_rx_cfg_if #(.DATA_BITS(7)) if2 ();
  assign if0.rx = rx0;
  assign if1.rx = rx1;
  assign if2.rx = rx2;

  uart_rx_cfg #(.CLKS_PER_BIT(CPB0)) u0 (.clk(clk), .rst(rst), .bus(if0.slave));
  uart_rx_cfg #(.CLKS_PER_BIT(CPB1), .PARITY_MODE(PARITY_EVEN)) u1 (
    .clk(clk), .rst(rst), .bus(if1.slave));
  uart_rx_cfg #(.CLKS_PER_BIT(CPB2), .DATA_BITS(7), .PARITY_MODE(PARITY_ODD),
                .STOP_BITS(2)) u2 (.clk(clk), .rst(rst), .bus(if2.slave));

  typedef struct {
    logic [8:0] d;
    logic       p;
    logic       f;
  } exp_t;

  typedef struct {
    int         w;
    logic [8:0] d;
    logic       pbit;
    logic [1:0] stopv;
    int         gap;
    logic [8:0] xd;
    logic       xp;
    logic       xf;
  } vec_t;

  exp_t       q0[$], q1[$], q2[$];
  int         total = 0, pass = 0;
  int         vcnt[3], vcyc[3], nexp[3];
  logic [8:0] last_d[3];

  function automatic int cpb(input int w);
    return (w == 0) ? CPB0 : (w == 1) ? CPB1 : CPB2;
  endfunction
  function automatic int dbits(input int w);
    return (w == 2) ? 7 : 8;
  endfunction
  function automatic int pmode(input int w);
    return (w == 0) ? PARITY_NONE : (w == 1) ? PARITY_EVEN : PARITY_ODD;
  endfunction
  function automatic int nstop(input int w);
    return (w == 2) ? 2 : 1;
  endfunction

  function automatic exp_t mk(input logic [8:0] d, input logic p, input logic f);
    exp_t e;
    e.d = d; e.p = p; e.f = f;
    return e;
  endfunction

  // Frame-level reference: what a receiver must report for a given line frame.
  function automatic exp_t model(input int w, input logic [8:0] d, input logic pbit,
                                 input logic [1:0] stopv);
    exp_t e;
    int   ones;
    e.d  = d & 9'((1 << dbits(w)) - 1);
    ones = $countones(e.d) + int'(pbit);
    e.p  = 1'b0;
    if (pmode(w) == PARITY_EVEN) e.p = (ones % 2) != 0;
    if (pmode(w) == PARITY_ODD)  e.p = (ones % 2) != 1;
    e.f  = !stopv[0] || (nstop(w) == 2 && !stopv[1]);
    return e;
  endfunction

  function automatic logic good_pbit(input int w, input logic [8:0] d);
    int ones;
    ones = $countones(d & 9'((1 << dbits(w)) - 1));
    return (pmode(w) == PARITY_ODD) ? ((ones % 2) == 0) : ((ones % 2) == 1);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act === req) pass++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
  endtask

  task automatic push(input int w, input exp_t e);
    nexp[w]++;
    case (w)
      0:       q0.push_back(e);
      1:       q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  task automatic got(input int w, input logic [8:0] d, input logic p, input logic f);
    exp_t e;
    logic have;
    have    = 1'b0;
    vcnt[w]++;
    vcyc[w] = cyc;
    case (w)
      0:       if (q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end
      1:       if (q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
      default: if (q2.size() > 0) begin e = q2.pop_front(); have = 1'b1; end
    endcase
    if (!have) begin
      total++;
      $display("FAIL unexpected_valid dut%0d: got valid data=0x%0h, required no valid", w, d);
    end else begin
      chk($sformatf("data_dut%0d", w), 32'(d), 32'(e.d));
      chk($sformatf("parity_err_dut%0d", w), 32'(p), 32'(e.p));
      chk($sformatf("frame_err_dut%0d", w), 32'(f), 32'(e.f));
      last_d[w] = e.d;
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (if0.valid) got(0, {1'b0, if0.data}, if0.parity_err, if0.frame_err);
      if (if1.valid) got(1, {1'b0, if1.data}, if1.parity_err, if1.frame_err);
      if (if2.valid) got(2, {2'b0, if2.data}, if2.parity_err, if2.frame_err);
    end
  end

  task automatic drive(input int w, input logic v);
    case (w)
      0:       rx0 = v;
      1:       rx1 = v;
      default: rx2 = v;
    endcase
  endtask

  task automatic bit_period(input int w, input logic v);
    drive(w, v);
    repeat (cpb(w)) @(posedge clk);
    #1;
  endtask

  task automatic send(input int w, input logic [8:0] d, input logic pbit, input logic [1:0] stopv);
    bit_period(w, 1'b0);
    for (int i = 0; i < dbits(w); i++) bit_period(w, d[i]);
    if (pmode(w) != PARITY_NONE) bit_period(w, pbit);
    for (int i = 0; i < nstop(w); i++) bit_period(w, stopv[i]);
    drive(w, 1'b1);
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((q0.size() + q1.size() + q2.size()) != 0 && t < 3000) begin
      @(posedge clk);
      t++;
    end
    repeat (2) @(posedge clk);
    #1;
    chk("pending_frames", 32'(q0.size() + q1.size() + q2.size()), 32'd0);
  endtask

  vec_t       tbl[10];
  int         c0, v, w, gap;
  logic [8:0] d;
  logic       pb;
  logic [1:0] sv;

  initial begin
    for (int i = 0; i < 3; i++) begin vcnt[i] = 0; nexp[i] = 0; vcyc[i] = 0; last_d[i] = '0; end

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_data0", 32'(if0.data), 32'd0);
    chk("rst_valid0", 32'(if0.valid), 32'd0);
    chk("rst_busy0", 32'(if0.busy), 32'd0);
    chk("rst_errs1", 32'({if1.parity_err, if1.frame_err}), 32'd0);
    chk("rst_busy2", 32'(if2.busy), 32'd0);
    rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;

    // 0xA5 8N1 with exact valid latency from the start edge
    c0 = cyc;
    push(0, mk(9'h0A5, 1'b0, 1'b0));
    send(0, 9'h0A5, 1'b0, 2'b11);
    repeat (4) @(posedge clk);
    #1;
    chk("a5_valid_latency", 32'(vcyc[0] - c0), 32'd156);
    chk("a5_valid_count", 32'(vcnt[0]), 32'd1);

    // Stop held low for 3 bit periods, then a clean frame
    push(0, mk(9'h055, 1'b0, 1'b1));
    d = 9'h055;
    bit_period(0, 1'b0);
    for (int i = 0; i < 8; i++) bit_period(0, d[i]);
    repeat (3) bit_period(0, 1'b0);
    chk("break_busy_high", 32'(if0.busy), 32'd1);
    chk("break_frame_delivered", 32'(vcnt[0]), 32'd2);
    drive(0, 1'b1);
    repeat (4) @(posedge clk);
    #1;
    chk("break_busy_released", 32'(if0.busy), 32'd0);
    push(0, mk(9'h03C, 1'b0, 1'b0));
    send(0, 9'h03C, 1'b0, 2'b11);
    drain();

    // 4-cycle glitch is a false start
    v = vcnt[0];
    drive(0, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    drive(0, 1'b1);
    chk("glitch_busy_start", 32'(if0.busy), 32'd1);
    repeat (CPB0) @(posedge clk);
    #1;
    chk("glitch_busy_idle", 32'(if0.busy), 32'd0);
    chk("glitch_no_valid", 32'(vcnt[0]), 32'(v));

    // Reset in the middle of 0x12, line still low when reset releases
    d = 9'h012;
    bit_period(0, 1'b0);
    for (int i = 0; i < 3; i++) bit_period(0, d[i]);
    drive(0, d[3]);
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("midrst_data_cleared", 32'(if0.data), 32'd0);
    chk("midrst_busy", 32'(if0.busy), 32'd0);
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    drive(0, 1'b1);
    repeat (2 * CPB0) @(posedge clk);
    #1;
    chk("midrst_idle", 32'(if0.busy), 32'd0);
    chk("midrst_no_valid", 32'(vcnt[0]), 32'(v));
    push(0, mk(9'h034, 1'b0, 1'b0));
    send(0, 9'h034, 1'b0, 2'b11);
    drain();
    chk("midrst_one_valid", 32'(vcnt[0]), 32'(v + 1));

    // Vector table: w, data, parity bit, stop bits, gap, expected data/perr/ferr
    tbl[0] = '{1, 9'h003, 1'b1, 2'b11,  0, 9'h003, 1'b1, 1'b0};
    tbl[1] = '{1, 9'h003, 1'b0, 2'b11,  0, 9'h003, 1'b0, 1'b0};
    tbl[2] = '{2, 9'h000, 1'b1, 2'b11,  0, 9'h000, 1'b0, 1'b0};
    tbl[3] = '{2, 9'h0FF, 1'b0, 2'b11,  0, 9'h07F, 1'b0, 1'b0};
    tbl[4] = '{2, 9'h081, 1'b0, 2'b11, 20, 9'h001, 1'b0, 1'b0};
    tbl[5] = '{0, 9'h0FF, 1'b0, 2'b00, 40, 9'h0FF, 1'b0, 1'b1};
    tbl[6] = '{1, 9'h080, 1'b1, 2'b11,  0, 9'h080, 1'b0, 1'b0};
    tbl[7] = '{1, 9'h07E, 1'b1, 2'b11,  0, 9'h07E, 1'b1, 1'b0};
    tbl[8] = '{2, 9'h055, 1'b1, 2'b10,  0, 9'h055, 1'b0, 1'b1};
    tbl[9] = '{2, 9'h02A, 1'b0, 2'b01, 20, 9'h02A, 1'b0, 1'b1};
    for (int i = 0; i < 10; i++) begin
      push(tbl[i].w, mk(tbl[i].xd, tbl[i].xp, tbl[i].xf));
      send(tbl[i].w, tbl[i].d, tbl[i].pbit, tbl[i].stopv);
      if (tbl[i].gap > 0) begin
        repeat (tbl[i].gap) @(posedge clk);
        #1;
      end
    end
    drain();

    // Random frames with occasional parity and stop-bit faults
    for (int n = 0; n < 45; n++) begin
      w  = int'($urandom_range(0, 2));
      d  = 9'($urandom);
      pb = good_pbit(w, d) ^ ($urandom_range(0, 4) == 0);
      sv = 2'b11;
      if ($urandom_range(0, 5) == 0) sv[$urandom_range(0, nstop(w) - 1)] = 1'b0;
      push(w, model(w, d, pb, sv));
      send(w, d, pb, sv);
      gap = sv[nstop(w) - 1] ? int'($urandom_range(0, 2)) : cpb(w) + int'($urandom_range(0, 5));
      if (gap > 0) begin
        repeat (gap) @(posedge clk);
        #1;
      end
    end
    drain();

    // Outputs hold between frames; every sent frame produced exactly one valid
    repeat (50) @(posedge clk);
    #1;
    chk("hold_data0", 32'({1'b0, if0.data}), 32'(last_d[0]));
    chk("hold_data1", 32'({1'b0, if1.data}), 32'(last_d[1]));
    chk("hold_data2", 32'({2'b0, if2.data}), 32'(last_d[2]));
    for (int i = 0; i < 3; i++) chk($sformatf("valid_total_dut%0d", i), 32'(vcnt[i]), 32'(nexp[i]));

    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
